// File: rtl/field_pkg.sv
// Shared state encoding and default sizing for the field serializer.
// Optional feature macro: FIELD_SERIALIZER_SIGNED_EN.
package field_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int DEF_FIELD_W = 4;
  localparam int DEF_NFIELDS = 2;
  localparam int DEF_OUT_W   = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/field_extend.sv
// Picks one field from a packed word and widens it to the output width.
// FIELD_SERIALIZER_SIGNED_EN selects sign extension, else zero extension.
module field_extend
  import field_pkg::*;
#(
  parameter int FIELD_W = DEF_FIELD_W,
  parameter int NFIELDS = DEF_NFIELDS,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int IDX_W   = idx_w(DEF_NFIELDS)
) (
  input  logic [NFIELDS*FIELD_W-1:0] word_i,
  input  logic [IDX_W-1:0]           idx_i,
  output logic [OUT_W-1:0]           ext_o
);

  logic [NFIELDS*FIELD_W-1:0] shifted;
  logic [FIELD_W-1:0]         field;

  // Field 0 sits in the MSBs, so shift the selected one down to bit 0.
  always_comb begin
    shifted = word_i >> ((NFIELDS - 1 - int'(idx_i)) * FIELD_W);
    field   = shifted[FIELD_W-1:0];
`ifdef FIELD_SERIALIZER_SIGNED_EN
    ext_o   = OUT_W'($signed(field));
`else
    ext_o   = OUT_W'(field);
`endif
  end

endmodule

// File: rtl/field_serializer.sv
// Accepts a packed word and emits its fields one per handshake, MSB first.
// Build option FIELD_SERIALIZER_SIGNED_EN sign-extends each field.
module field_serializer
  import field_pkg::*;
#(
  parameter int FIELD_W = DEF_FIELD_W,
  parameter int NFIELDS = DEF_NFIELDS,
  parameter int OUT_W   = DEF_OUT_W,
  localparam int IDX_W  = idx_w(NFIELDS),
  localparam int WORD_W = NFIELDS * FIELD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [15:0]       words_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFIELDS - 1);

  state_e             state_q;
  logic [WORD_W-1:0]  word_q;
  logic [IDX_W-1:0]   idx_q;
  logic [15:0]        done_q;
  logic               fire_last;

  assign out_valid  = (state_q == EMIT);
  assign out_last   = out_valid && (idx_q == LAST_IDX);
  assign fire_last  = out_valid && out_ready && out_last;
  assign in_ready   = !out_valid || fire_last;
  assign out_idx    = idx_q;
  assign words_done = done_q;

  field_extend #(
    .FIELD_W (FIELD_W),
    .NFIELDS (NFIELDS),
    .OUT_W   (OUT_W),
    .IDX_W   (IDX_W)
  ) u_ext (
    .word_i (word_q),
    .idx_i  (idx_q),
    .ext_o  (out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      done_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            word_q  <= in_data;
            idx_q   <= '0;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              done_q <= done_q + 16'd1;
              // A waiting word is taken on the last beat: no bubble.
              if (in_valid) begin
                word_q <= in_data;
                idx_q  <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/field_serializer.md
FIELD_SERIALIZER -- requirements
Module: field_serializer

Interface
REQ-001 SHALL have parameter FIELD_W, default 4, bit width of one packed field.
REQ-002 SHALL have parameter NFIELDS, default 2, number of fields per input word (>=1).
REQ-003 SHALL have parameter OUT_W, default 8, output field width (>= FIELD_W).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  input word offered.
REQ-007 SHALL have port in_ready  output  1  block accepts input word.
REQ-008 SHALL have port in_data  input  NFIELDS*FIELD_W  packed word; first-declared field occupies MSBs.
REQ-009 SHALL have port out_valid  output  1  output field valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts field.
REQ-011 SHALL have port out_data  output  OUT_W  current field, extended to OUT_W.
REQ-012 SHALL have port out_idx  output  $clog2(NFIELDS) (min 1)  index of current field, 0 = MSB field.
REQ-013 SHALL have port out_last  output  1  current field is index NFIELDS-1.
REQ-014 SHALL have port words_done  output  16  count of fully emitted words, wraps 16'hFFFF -> 0.

Function
REQ-015 SHALL implement states IDLE (no word held) and EMIT (word held, fields pending).
REQ-016 In IDLE: in_ready=1, out_valid=0; on in_valid capture in_data, out_idx<=0, go EMIT.
REQ-017 Latency: word accepted in cycle t SHALL present field 0 with out_valid=1 in cycle t+1.
REQ-018 In EMIT: out_data, out_idx, out_last SHALL hold stable while out_valid && !out_ready.
REQ-019 On out_valid && out_ready && !out_last: out_idx increments by 1 next cycle.
REQ-020 On out_valid && out_ready && out_last: words_done increments; in_ready=1 that cycle.
REQ-021 Simultaneous last-field handshake and in_valid SHALL capture the new word and remain in EMIT with out_idx=0 (no bubble).
REQ-022 Last-field handshake without in_valid SHALL return to IDLE.
REQ-023 in_ready SHALL be 0 in EMIT except during a last-field handshake; in_data ignored otherwise.
REQ-024 NFIELDS=1: every field SHALL have out_last=1 and out_idx=0.
REQ-025 Field k SHALL be in_data bits [(NFIELDS-k)*FIELD_W-1 : (NFIELDS-k-1)*FIELD_W].

Reset
REQ-026 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, words_done=0.
REQ-027 Reset mid-word SHALL discard remaining fields without incrementing words_done.

Configuration
REQ-028 Macro FIELD_SERIALIZER_SIGNED_EN defined: out_data SHALL be sign-extended from FIELD_W to OUT_W.
REQ-029 Macro undefined: out_data SHALL be zero-extended (fields treated unsigned); no other behaviour differs.

Structure
REQ-030 Package field_pkg SHALL hold the state enum (IDLE, EMIT) and default parameter constants.
REQ-031 Sub-module field_extend SHALL perform field select plus zero/sign extension (combinational).

Verification
REQ-032 FIELD_W=4, NFIELDS=2, in_data=8'd200, out_ready=1 -> out_data 8'h0C (idx0) then 8'h08 (idx1, last), words_done=1.
REQ-033 Same stimulus with FIELD_SERIALIZER_SIGNED_EN -> out_data 8'hFC then 8'hF8.
REQ-034 out_ready=0 for 3 cycles on field 0 -> out_data 8'h0C, out_idx=0 held; in_ready=0 throughout.
REQ-035 Back-to-back words 8'hC8, 8'h3A with in_valid and out_ready held high -> fields 0C,08,03,0A in 4 consecutive cycles, words_done=2.
REQ-036 rst_n pulsed low after field 0 of 8'hC8 -> out_valid=0, words_done=0, next word starts at out_idx=0.
REQ-037 Preload words_done to 16'hFFFF, complete one word -> words_done=0.
